acl_spi_reader: RTL
===================

# acl_spi_reader

SPI master that configures an ADXL362 accelerometer and periodically reads the X/Y/Z acceleration registers. It runs directly downstream of `iclk_gen` and is clocked by its 4 MHz output. It generates a 1 MHz SPI mode-0 link (SCLK = clk/4) to the sensor pins. Sign-extended 12-bit samples with a one-cycle valid strobe are presented to the display and processing logic.

## Interface
Parameters:
- `POR_WAIT`, default 20000: clk cycles to wait after reset before configuring. 20000 cycles is 5 ms at 4 MHz.
- `SAMPLE_PERIOD`, default 40000: clk cycles from one read start to the next read start. 40000 cycles is 100 Hz.
- `GAP_CYCLES`, default 4: minimum cycles `acl_cs_n` stays high between transactions.

Ports:
- `clk_4MHz` in, 1: system clock for this block; the only clock.
- `reset_n` in, 1: asynchronous, active-low reset.
- `acl_miso` in, 1: sensor MISO.
- `acl_sclk` out, 1: SPI clock; idles low.
- `acl_mosi` out, 1: SPI data to the sensor.
- `acl_cs_n` out, 1: chip select, active low.
- `cfg_done` out, 1: high once the configuration write has completed; held until reset.
- `busy` out, 1: high whenever `acl_cs_n` is low.
- `acc_x`, `acc_y`, `acc_z` out, 16 each: signed samples, sign-extended from 12 bits.
- `acc_temp` out, 16: signed temperature sample; only present when `ACL_TEMP_EN` is defined.
- `data_valid` out, 1: one-cycle pulse when new samples are presented.

## Operation
- All outputs reset to 0, except `acl_cs_n`, which resets to 1.
- Reset is asserted asynchronously. When `reset_n` goes low mid-transaction:
  - `acl_cs_n` goes high and `acl_sclk` goes low immediately.
  - The FSM returns to `POR`.
  - Partially received data is discarded.
- FSM states and transitions:
  - `POR`: count `POR_WAIT` cycles, then go to `CFG`.
  - `CFG`: write 24 bits, 0x0A 0x2D 0x02 (write command, POWER_CTL address, measurement mode). Then set `cfg_done` and go to `GAP`.
  - `GAP`: hold `acl_cs_n` high for `GAP_CYCLES` cycles, then go to `WAIT`.
  - `WAIT`: go to `READ` when the period counter reaches `SAMPLE_PERIOD`-1, or immediately if it has already expired.
  - `READ`: send 0x0B 0x0E (read command, XDATA_L address), then clock in 6 bytes: XL XH YL YH ZL ZH. Go to `DONE`.
  - `DONE`: latch outputs, pulse `data_valid`, go to `GAP`.
- Period counter:
  - Restarts at 0 on the cycle `READ` is entered.
  - Saturates at `SAMPLE_PERIOD`-1.
  - If `SAMPLE_PERIOD` is shorter than a read plus `GAP_CYCLES`, reads run back-to-back, separated by exactly `GAP_CYCLES`.
- Bytes are transmitted MSB first. `acl_mosi` is 0 during the received-data phase.
- Sample assembly:
  - `acc_x` = sign-extension of {XH[3:0], XL}, i.e. bit 11 is replicated into bits 15:12.
  - XH[7:4] is ignored.
  - `acc_y` and `acc_z` are assembled the same way.
- `acc_*` change only on the `data_valid` cycle and hold otherwise.

## Timing
- Each SPI bit takes 4 clk cycles, phases 0–3:
  - `acl_sclk` is 0 in phases 0–1 and 1 in phases 2–3.
  - `acl_mosi` updates at the start of phase 0.
  - `acl_miso` is captured on the clk edge that ends phase 2.
  - All outputs are registered.
- Each transaction is framed as follows:
  - `acl_cs_n` falls one full cycle before phase 0 of bit 0 (setup).
  - `acl_cs_n` rises one cycle after phase 3 of the last bit (hold).
- Transaction lengths, as `acl_cs_n`-low cycles:
  - CFG: 1 + 24·4 + 1 = 98.
  - READ: 1 + 64·4 + 1 = 258 (322 with `ACL_TEMP_EN`).
- `data_valid` asserts the cycle after `acl_cs_n` rises at the end of a read.
- The first `acl_cs_n` fall occurs exactly `POR_WAIT` cycles after `reset_n` deasserts.

## Configuration
- `ACL_TEMP_EN` defined:
  - READ clocks in 8 bytes (80 data+cmd bits total): XL XH YL YH ZL ZH TL TH.
  - `acc_temp` = sign-extension of {TH[3:0], TL} and is latched with the other samples.
- `ACL_TEMP_EN` undefined:
  - READ uses 6 data bytes.
  - The `acc_temp` port and its logic do not exist.

## Test plan
- Reset release with `POR_WAIT`=100: `acl_cs_n` falls at cycle 100. MOSI carries 0x0A, 0x2D, 0x02 across 98 low cycles; `cfg_done` rises afterwards.
- MISO model returns XL=0x34 XH=0x02 YL=0xFF YH=0x0F ZL=0x00 ZH=0x08. Required: `acc_x`=0x0234, `acc_y`=0xFFFF, `acc_z`=0xF800, with exactly one `data_valid` pulse.
- MISO model returns XH=0xF1: the upper nibble is ignored, so `acc_x`[15:8]=0x01.
- `SAMPLE_PERIOD`=1000:
  - Successive `acl_cs_n` falling edges of READs are 1000 cycles apart.
  - With `SAMPLE_PERIOD`=10, falling edges are 258+`GAP_CYCLES` apart.
- `reset_n` pulled low at bit 30 of a READ:
  - `acl_cs_n` goes to 1 the same cycle, asynchronously.
  - No `data_valid` is produced, and outputs are 0.
  - After release, the sequence restarts with `POR` and `CFG`.
- With `ACL_TEMP_EN` and TL=0x10 TH=0x0F: `acc_temp`=0xFF10 and the READ frame is 322 cycles.

Source files
------------

// File: rtl/acl_spi_reader.sv
// acl_spi_reader
// SPI mode-0 master for an ADXL362 accelerometer. After a power-on wait it
// writes POWER_CTL to enter measurement mode, then periodically burst-reads
// XDATA_L..ZDATA_H and presents sign-extended 12-bit samples with a one-cycle
// valid strobe. SCLK = clk/4; every output is registered.
//
// Ports:
//   clk_4MHz   in   system clock (only clock)
//   reset_n    in   asynchronous active-low reset
//   acl_miso   in   sensor MISO
//   acl_sclk   out  SPI clock, idles low
//   acl_mosi   out  SPI data to sensor, MSB first, 0 while receiving
//   acl_cs_n   out  chip select, active low
//   cfg_done   out  high once the configuration write has completed
//   busy       out  high whenever acl_cs_n is low
//   acc_x/y/z  out  16-bit signed samples (sign-extended 12-bit)
//   acc_temp   out  16-bit signed temperature (only with ACL_TEMP_EN)
//   data_valid out  one-cycle pulse when new samples are presented
//
// Optional feature macro: ACL_TEMP_EN (adds TL/TH to the burst and acc_temp).
module acl_spi_reader #(
  parameter int POR_WAIT      = 20000,
  parameter int SAMPLE_PERIOD = 40000,
  parameter int GAP_CYCLES    = 4
) (
  input  logic        clk_4MHz,
  input  logic        reset_n,
  input  logic        acl_miso,
  output logic        acl_sclk,
  output logic        acl_mosi,
  output logic        acl_cs_n,
  output logic        cfg_done,
  output logic        busy,
  output logic [15:0] acc_x,
  output logic [15:0] acc_y,
  output logic [15:0] acc_z,
`ifdef ACL_TEMP_EN
  output logic [15:0] acc_temp,
`endif
  output logic        data_valid
);

`ifdef ACL_TEMP_EN
  localparam int RX_BYTES = 8;
`else
  localparam int RX_BYTES = 6;
`endif
  localparam int CFG_BITS = 24;
  localparam int RX_W     = 8 * RX_BYTES;
  localparam int RD_BITS  = 16 + RX_W;
  localparam int TW       = 10;
  localparam int PORW     = $clog2(POR_WAIT + 1);
  localparam int PW       = $clog2(SAMPLE_PERIOD + 1);
  localparam int GW       = $clog2(GAP_CYCLES + 1);

  // Frame cycle index: 0 = CS setup, 1..4N = bits, 4N+1 = CS hold.
  localparam logic [TW-1:0]   CFG_LAST = TW'(4 * CFG_BITS + 1);
  localparam logic [TW-1:0]   RD_LAST  = TW'(4 * RD_BITS + 1);
  localparam logic [PORW-1:0] POR_LAST = PORW'(POR_WAIT - 1);
  localparam logic [PW-1:0]   PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [23:0]     CFG_WORD = 24'h0A2D02;
  localparam logic [15:0]     RD_CMD   = 16'h0B0E;

  typedef enum logic [2:0] {
    ST_POR  = 3'd0,
    ST_CFG  = 3'd1,
    ST_GAP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_READ = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  state_t          state_r, state_nxt_s;
  logic [TW-1:0]   tcnt_r, tcnt_nxt_s, bit_t_s, cap_t_s;
  logic [TW-3:0]   bit_idx_s;
  logic [PORW-1:0] por_cnt_r;
  logic [PW-1:0]   per_cnt_r;
  logic [GW-1:0]   gap_cnt_r;
  logic [RX_W-1:0] rx_r;
  logic            per_expired_s, capture_s;
  logic            cs_n_s, sclk_s, mosi_s, busy_s, cfg_done_s;
  logic            cs_n_r, sclk_r, mosi_r, busy_r, cfg_done_r, dv_r;
  logic [15:0]     acc_x_r, acc_y_r, acc_z_r;
  logic [7:0]      xl_s, xh_s, yl_s, yh_s, zl_s, zh_s;
  logic            unused_hi_s;

  assign per_expired_s = (per_cnt_r == PER_LAST);
  // Capture on the edge ending phase 2, data bits only (after the 16 command bits).
  assign cap_t_s   = tcnt_r - TW'(1);
  assign capture_s = (state_r == ST_READ) && (cap_t_s[1:0] == 2'd2) &&
                     (cap_t_s[TW-1:2] >= (TW-2)'(16));

  assign xl_s = rx_r[RX_W-1  -: 8];
  assign xh_s = rx_r[RX_W-9  -: 8];
  assign yl_s = rx_r[RX_W-17 -: 8];
  assign yh_s = rx_r[RX_W-25 -: 8];
  assign zl_s = rx_r[RX_W-33 -: 8];
  assign zh_s = rx_r[RX_W-41 -: 8];

`ifdef ACL_TEMP_EN
  logic [7:0]  tl_s, th_s;
  logic [15:0] acc_t_r;
  assign tl_s = rx_r[RX_W-49 -: 8];
  assign th_s = rx_r[RX_W-57 -: 8];
  // Upper nibbles of the high bytes carry no sample information.
  assign unused_hi_s = ^{xh_s[7:4], yh_s[7:4], zh_s[7:4], th_s[7:4]};
  assign acc_temp = acc_t_r;
`else
  // Upper nibbles of the high bytes carry no sample information.
  assign unused_hi_s = ^{xh_s[7:4], yh_s[7:4], zh_s[7:4]};
`endif

  // State register and frame cycle index.
  always_ff @(posedge clk_4MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_POR;
      tcnt_r  <= {TW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      tcnt_r  <= tcnt_nxt_s;
    end
  end

  // Next-state and next frame index.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_POR:  if (por_cnt_r == POR_LAST) state_nxt_s = ST_CFG;  else state_nxt_s = ST_POR;
      ST_CFG:  if (tcnt_r == CFG_LAST)    state_nxt_s = ST_GAP;  else state_nxt_s = ST_CFG;
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          // An already-expired period skips WAIT so back-to-back reads keep the exact gap.
          if (per_expired_s) state_nxt_s = ST_READ; else state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      ST_WAIT: if (per_expired_s)         state_nxt_s = ST_READ; else state_nxt_s = ST_WAIT;
      ST_READ: if (tcnt_r == RD_LAST)     state_nxt_s = ST_DONE; else state_nxt_s = ST_READ;
      ST_DONE: state_nxt_s = ST_GAP;
      default: state_nxt_s = ST_POR;
    endcase
    if (((state_r == ST_CFG) || (state_r == ST_READ)) && (state_nxt_s == state_r)) begin
      tcnt_nxt_s = tcnt_r + TW'(1);
    end else begin
      tcnt_nxt_s = {TW{1'b0}};
    end
  end

  // Pin values decoded from the next state so the registered pins line up with state_r.
  always_comb begin
    cs_n_s    = 1'b1;
    sclk_s    = 1'b0;
    mosi_s    = 1'b0;
    bit_t_s   = tcnt_nxt_s - TW'(1);
    bit_idx_s = bit_t_s[TW-1:2];
    if ((state_nxt_s == ST_CFG) && (tcnt_nxt_s != {TW{1'b0}}) && (tcnt_nxt_s != CFG_LAST)) begin
      cs_n_s = 1'b0;
      sclk_s = (bit_t_s[1:0] >= 2'd2);
      mosi_s = CFG_WORD[5'd23 - bit_idx_s[4:0]];
    end else if ((state_nxt_s == ST_READ) && (tcnt_nxt_s != {TW{1'b0}}) && (tcnt_nxt_s != RD_LAST)) begin
      cs_n_s = 1'b0;
      sclk_s = (bit_t_s[1:0] >= 2'd2);
      if (bit_idx_s < (TW-2)'(16)) mosi_s = RD_CMD[4'd15 - bit_idx_s[3:0]];
      else                         mosi_s = 1'b0;
    end else if ((state_nxt_s == ST_CFG) || (state_nxt_s == ST_READ)) begin
      cs_n_s = 1'b0;
    end else begin
      cs_n_s = 1'b1;
    end
    busy_s     = ~cs_n_s;
    cfg_done_s = cfg_done_r | ((state_r == ST_CFG) && (state_nxt_s == ST_GAP));
  end

  // Power-on, sample-period and inter-frame gap counters.
  always_ff @(posedge clk_4MHz or negedge reset_n) begin
    if (!reset_n) begin
      por_cnt_r <= {PORW{1'b0}};
      per_cnt_r <= {PW{1'b0}};
      gap_cnt_r <= {GW{1'b0}};
    end else begin
      if (state_r == ST_POR) por_cnt_r <= por_cnt_r + PORW'(1);
      else                   por_cnt_r <= {PORW{1'b0}};
      if ((state_nxt_s == ST_READ) && (state_r != ST_READ)) per_cnt_r <= {PW{1'b0}};
      else if (!per_expired_s)                              per_cnt_r <= per_cnt_r + PW'(1);
      else                                                  per_cnt_r <= per_cnt_r;
      // DONE counts as the first CS-high cycle after a read.
      if ((state_r == ST_DONE) || (state_r == ST_GAP)) gap_cnt_r <= gap_cnt_r + GW'(1);
      else                                             gap_cnt_r <= {GW{1'b0}};
    end
  end

  // MISO shift register; every read overwrites all RX_W bits.
  always_ff @(posedge clk_4MHz or negedge reset_n) begin
    if (!reset_n) rx_r <= {RX_W{1'b0}};
    else if (capture_s) rx_r <= {rx_r[RX_W-2:0], acl_miso};
    else rx_r <= rx_r;
  end

  // Registered outputs; samples latch one cycle after DONE together with data_valid.
  always_ff @(posedge clk_4MHz or negedge reset_n) begin
    if (!reset_n) begin
      cs_n_r     <= 1'b1;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      busy_r     <= 1'b0;
      cfg_done_r <= 1'b0;
      dv_r       <= 1'b0;
      acc_x_r    <= 16'h0000;
      acc_y_r    <= 16'h0000;
      acc_z_r    <= 16'h0000;
`ifdef ACL_TEMP_EN
      acc_t_r    <= 16'h0000;
`endif
    end else begin
      cs_n_r     <= cs_n_s;
      sclk_r     <= sclk_s;
      mosi_r     <= mosi_s;
      busy_r     <= busy_s;
      cfg_done_r <= cfg_done_s;
      if (state_r == ST_DONE) begin
        dv_r    <= 1'b1;
        acc_x_r <= sext12({xh_s[3:0], xl_s});
        acc_y_r <= sext12({yh_s[3:0], yl_s});
        acc_z_r <= sext12({zh_s[3:0], zl_s});
`ifdef ACL_TEMP_EN
        acc_t_r <= sext12({th_s[3:0], tl_s});
`endif
      end else begin
        dv_r <= 1'b0;
      end
    end
  end

  assign acl_cs_n   = cs_n_r;
  assign acl_sclk   = sclk_r;
  assign acl_mosi   = mosi_r;
  assign busy       = busy_r;
  assign cfg_done   = cfg_done_r;
  assign data_valid = dv_r;
  assign acc_x      = acc_x_r;
  assign acc_y      = acc_y_r;
  assign acc_z      = acc_z_r;

endmodule
